// File: rtl/npc_pkg.sv
// Shared NPC definitions: memory responder state encoding and the physical
// memory access routines used by both the core and the responder.
package npc_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    // Width of the programmable wait counter (LATENCY range 0..15).
    localparam int unsigned LAT_W = 4;

    // Simulated physical memory: sparse word store keyed by aligned byte address.
    // Words never written read back as zero.
    logic [31:0] pmem_mem [bit [31:0]];

    // Access log, observable by anything importing the package.
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;
    bit [31:0]   pmem_last_waddr;
    bit [31:0]   pmem_last_wdata;
    bit [7:0]    pmem_last_wmask;

    // Word read at addr & ~3.
    function automatic int pmem_read_npc(input int addr);
        bit [31:0] a;
        a = 32'(addr) & 32'hFFFF_FFFC;
        pmem_rd_calls++;
        if (pmem_mem.exists(a)) begin
            return int'(pmem_mem[a]);
        end
        return 0;
    endfunction

    // Byte-lane write. wdata arrives unshifted; lane i of wdata lands at byte
    // (addr[1:0] + i) of the aligned word when wmask[i] is set.
    function automatic void pmem_write_npc(input int addr, input int wdata, input byte wmask);
        bit [31:0]   a;
        logic [31:0] w;
        bit [31:0]   d;
        int          off;
        a   = 32'(addr) & 32'hFFFF_FFFC;
        d   = 32'(wdata);
        off = int'(addr[1:0]);
        w   = pmem_mem.exists(a) ? pmem_mem[a] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i] && ((i + off) < 4)) begin
                w[8*(i+off) +: 8] = d[8*i +: 8];
            end
        end
        pmem_mem[a]     = w;
        pmem_wr_calls++;
        pmem_last_waddr = 32'(addr);
        pmem_last_wdata = d;
        pmem_last_wmask = 8'(wmask);
    endfunction

endpackage

// File: rtl/pmem_resp.sv
// Memory responder: accepts one load/store request, waits LATENCY cycles,
// performs exactly one memory access, then holds the response until taken.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once rsp_valid is raised the
// response payload stays stable until that transfer edge.
module pmem_resp
    import npc_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);

    mem_state_t       state;
    mem_state_t       state_n;
    logic [LAT_W-1:0] cnt;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_wmask;

    logic accept;
    logic access;
    logic rsp_done;

    // Transfer/event decode from registered state.
    always_comb begin
        accept   = 1'b0;
        access   = 1'b0;
        rsp_done = 1'b0;
        if (state == MEM_IDLE) begin
            accept = req_valid;
        end
        if ((state == MEM_BUSY) && (cnt == '0)) begin
            access = 1'b1;
        end
        if (state == MEM_RESP) begin
            rsp_done = rsp_ready;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            MEM_IDLE: if (accept)   state_n = MEM_BUSY;
            MEM_BUSY: if (access)   state_n = MEM_RESP;
            MEM_RESP: if (rsp_done) state_n = MEM_IDLE;
            default:                state_n = MEM_IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Wait counter: loaded on acceptance, counts down while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= LAT_LOAD;
        end else if ((state == MEM_BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture: later changes on req_* do not affect the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
        end
    end

    // Memory access (once per transaction) and response payload register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            if (!lat_we) begin
                rsp_rdata <= 32'(pmem_read_npc(int'(lat_addr)));
                rsp_err   <= 1'b0;
            end else if (lat_wmask != 4'h0) begin
                pmem_write_npc(int'(lat_addr), int'(lat_wdata), byte'({4'b0, lat_wmask}));
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end else begin
                // A write that touches no byte is rejected without a memory call.
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end else if (rsp_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        req_ready = (state == MEM_IDLE) && reset;
        rsp_valid = (state == MEM_RESP);
    end

endmodule

// File: tb/tb_pmem_resp.sv
// Bench for pmem_resp: three responders with LATENCY 1, 0 and 5 share one
// simulated memory; directed steps plus a few random store/load pairs.
module tb_pmem_resp;
    import npc_pkg::*;

    localparam int N = 3;

    logic        clk;
    logic        reset     [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wmask [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    int n_vec;
    int n_err;
    logic [32:0] exp_q[$];

    pmem_resp #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    pmem_resp #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    pmem_resp #(.LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on responder d. stall = cycles rsp_ready is held low
    // after rsp_valid rises; extra requests are offered during the stall.
    task automatic run_txn(input int d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] exp_rdata, input bit exp_err,
                           input int stall);
        int lat;
        int rd0;
        int wr0;
        int exp_rd;
        int exp_wr;
        logic [32:0] exp;
        lat    = lat_of(d);
        exp_rd = we ? 0 : 1;
        exp_wr = (we && (wmask != 4'h0)) ? 1 : 0;
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        check("req_ready_idle", req_ready[d], 1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        rsp_ready[d] = (stall == 0);
        rd0 = int'(pmem_rd_calls);
        wr0 = int'(pmem_wr_calls);
        @(posedge clk); #1;
        // Scramble inputs right after acceptance; the latched copy must be used.
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~addr;
        req_wdata[d] = ~wdata;
        req_wmask[d] = 4'hf;
        check("accept_no_call", 64'(int'(pmem_rd_calls) - rd0 + int'(pmem_wr_calls) - wr0), 0);
        check("accept_req_ready", req_ready[d], 0);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k <= lat) begin
                check("busy_rsp_valid", rsp_valid[d], 0);
            end
            @(posedge clk); #1;
            if (k <= lat) begin
                check("busy_no_call", 64'(int'(pmem_rd_calls) - rd0 + int'(pmem_wr_calls) - wr0), 0);
            end
        end
        check("rsp_valid_rise", rsp_valid[d], 1);
        check("rd_calls", 64'(int'(pmem_rd_calls) - rd0), 64'(exp_rd));
        check("wr_calls", 64'(int'(pmem_wr_calls) - wr0), 64'(exp_wr));
        if (exp_wr == 1) begin
            check("wr_addr", pmem_last_waddr, addr);
            check("wr_data", pmem_last_wdata, wdata);
            check("wr_mask", pmem_last_wmask, {4'b0, wmask});
        end
        for (int s = 0; s < stall; s++) begin
            req_valid[d] = 1'b1;
            @(posedge clk); #1;
            check("stall_rsp_valid", rsp_valid[d], 1);
            check("stall_req_ready", req_ready[d], 0);
            check("stall_payload", {rsp_err[d], rsp_rdata[d]}, exp_q[0]);
            check("stall_no_call", 64'(int'(pmem_rd_calls) - rd0 - exp_rd + int'(pmem_wr_calls) - wr0 - exp_wr), 0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        exp = exp_q.pop_front();
        check("rsp_payload", {rsp_err[d], rsp_rdata[d]}, exp);
        @(posedge clk); #1;
        check("post_hs_rsp_valid", rsp_valid[d], 0);
        check("post_hs_req_ready", req_ready[d], 1);
        check("post_hs_cleared", {rsp_err[d], rsp_rdata[d]}, 0);
    endtask

    initial begin
        int rd0;
        int wr0;
        logic [31:0] rnd;
        n_vec = 0;
        n_err = 0;
        for (int d = 0; d < N; d++) begin
            reset[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wmask[d] = '0;
            rsp_ready[d] = 1'b1;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("rst_req_ready", req_ready[d], 0);
            check("rst_rsp_valid", rsp_valid[d], 0);
            check("rst_rsp_rdata", rsp_rdata[d], 0);
            check("rst_rsp_err", rsp_err[d], 0);
        end
        for (int d = 0; d < N; d++) reset[d] = 1'b1;

        // LATENCY=1: store then unaligned load of the same word.
        run_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hf, 32'h0, 1'b0, 0);
        run_txn(0, 1'b0, 32'h8000_0012, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // LATENCY=0: sw, sb into lane 1, read back the merged word.
        wr0 = int'(pmem_wr_calls);
        run_txn(1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'hf, 32'h0, 1'b0, 0);
        run_txn(1, 1'b1, 32'h8000_0101, 32'h0000_00AB, 4'h1, 32'h0, 1'b0, 0);
        check("two_writes", 64'(int'(pmem_wr_calls) - wr0), 2);
        run_txn(1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 32'h1234_AB78, 1'b0, 0);

        // Backpressure on a read.
        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 5);

        // Zero-mask write is rejected and leaves memory untouched.
        run_txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b1, 2);
        run_txn(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Halfword store into upper lanes.
        run_txn(2, 1'b1, 32'h8000_0012, 32'h0000_CAFE, 4'h3, 32'h0, 1'b0, 0);
        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hCAFE_BEEF, 1'b0, 0);

        // Reset two cycles into a LATENCY=5 write: no memory call may follow.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h8000_0200;
        req_wdata[2] = 32'h5555_AAAA;
        req_wmask[2] = 4'hf;
        rd0 = int'(pmem_rd_calls);
        wr0 = int'(pmem_wr_calls);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset[2] = 1'b0;
        #1;
        check("mid_busy_rst_rsp_valid", rsp_valid[2], 0);
        check("mid_busy_rst_req_ready", req_ready[2], 0);
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_rst_no_call", 64'(int'(pmem_rd_calls) - rd0 + int'(pmem_wr_calls) - wr0), 0);
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        check("mid_busy_rel_req_ready", req_ready[2], 1);
        check("mid_busy_rel_rsp_valid", rsp_valid[2], 0);
        run_txn(2, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        // Reset while a response is waiting: the response is discarded.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h8000_0010;
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("resp_pending_valid", rsp_valid[0], 1);
        reset[0] = 1'b0;
        #1;
        check("resp_rst_rsp_valid", rsp_valid[0], 0);
        check("resp_rst_payload", {rsp_err[0], rsp_rdata[0]}, 0);
        @(negedge clk);
        reset[0]     = 1'b1;
        rsp_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("resp_rst_stays_idle", rsp_valid[0], 0);
        check("resp_rst_req_ready", req_ready[0], 1);

        // Random store/load pairs across the three responders.
        for (int i = 0; i < 4; i++) begin
            int d;
            d   = int'($urandom_range(0, N - 1));
            rnd = $urandom;
            run_txn(d, 1'b1, 32'h8000_0400 + 32'(4 * i), rnd, 4'hf, 32'h0, 1'b0, 0);
            d = int'($urandom_range(0, N - 1));
            run_txn(d, 1'b0, 32'h8000_0400 + 32'(4 * i), 32'h0, 4'h0, rnd, 1'b0,
                    int'($urandom_range(0, 2)));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
